// File: rtl/motor_ramp_sched_pkg.sv
// Shared types for the motor ramp scheduler: velocity type, FSM states, hold width.
package motor_sched_pkg;

  typedef logic signed [31:0] vel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } sched_state_e;

  localparam int unsigned HOLD_W = 16;

endpackage

// File: rtl/motor_ramp_sched_ramp_step.sv
// ramp_step: one rate-limited step of cur toward tgt, at most step_i per call.
module ramp_step
  import motor_sched_pkg::*;
(
  input  vel_t        cur_i,
  input  vel_t        tgt_i,
  input  logic [31:0] step_i,
  output vel_t        nxt_o
);

  logic signed [32:0] diff;
  logic        [32:0] mag;

  always_comb begin
    diff  = $signed({tgt_i[31], tgt_i}) - $signed({cur_i[31], cur_i});
    mag   = diff[32] ? 33'(-diff) : 33'(diff);
    nxt_o = tgt_i;
    // Once |diff| exceeds the step, cur +/- step lies strictly between cur and tgt,
    // so the 32-bit result cannot wrap.
    if (mag > {1'b0, step_i}) begin
      if (diff[32]) nxt_o = vel_t'(cur_i - step_i);
      else          nxt_o = vel_t'(cur_i + step_i);
    end
  end

endmodule

// File: rtl/motor_ramp_sched.sv
// motor_ramp_sched: accepts drive segments and slews both wheel targets at a bounded rate per tick.
// Optional watchdog auto-stop is built only when MOTOR_RAMP_WDOG_EN is defined.
module motor_ramp_sched
  import motor_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 200_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned STEP       = 16,
  parameter int unsigned ESTOP_STEP = 64,
  parameter int unsigned WDOG_TICKS = 500
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_r_v,
  input  logic [31:0]       cmd_l_v,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              estop,
  output logic [31:0]       r_target_rot_v,
  output logic [31:0]       l_target_rot_v,
  output logic              seg_done,
  output logic [1:0]        state,
  output logic              wdog_trip
);

  localparam int unsigned TICK_CYCLES = CLK_FREQ / TICK_HZ;
  localparam int unsigned TCW         = $clog2(TICK_CYCLES);

  logic [TCW-1:0]    tick_cnt_q;
  logic              tick;
  logic              accept;
  logic              at_tgt;
  logic              wdog_fire;
  logic [31:0]       step_sel;
  sched_state_e      state_q, state_d;
  vel_t              cur_r_q, cur_r_d, cur_l_q, cur_l_d;
  vel_t              tgt_r_q, tgt_r_d, tgt_l_q, tgt_l_d;
  vel_t              nxt_r, nxt_l;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_cnt_q, hold_cnt_d;
  logic              seg_done_q, seg_done_d;

  assign tick      = (tick_cnt_q == TCW'(TICK_CYCLES - 1));
  assign cmd_ready = ((state_q == IDLE) || (state_q == HOLD)) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign step_sel  = (state_q == STOP) ? ESTOP_STEP : STEP;
  assign at_tgt    = (nxt_r == tgt_r_q) && (nxt_l == tgt_l_q);

  ramp_step u_step_r (.cur_i(cur_r_q), .tgt_i(tgt_r_q), .step_i(step_sel), .nxt_o(nxt_r));
  ramp_step u_step_l (.cur_i(cur_l_q), .tgt_i(tgt_l_q), .step_i(step_sel), .nxt_o(nxt_l));

  always_comb begin
    state_d    = state_q;
    cur_r_d    = cur_r_q;
    cur_l_d    = cur_l_q;
    tgt_r_d    = tgt_r_q;
    tgt_l_d    = tgt_l_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    seg_done_d = 1'b0;
    if (estop) begin
      // Stepping only starts once STOP is the registered state.
      if ((state_q == STOP) && tick) begin
        cur_r_d = nxt_r;
        cur_l_d = nxt_l;
      end
      state_d = STOP;
      tgt_r_d = '0;
      tgt_l_d = '0;
      hold_d  = '0;
    end else if (accept) begin
      state_d    = RAMP;
      tgt_r_d    = cmd_r_v;
      tgt_l_d    = cmd_l_v;
      hold_d     = cmd_hold;
      hold_cnt_d = '0;
    end else if (wdog_fire) begin
      state_d = RAMP;
      tgt_r_d = '0;
      tgt_l_d = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        RAMP: if (tick) begin
          cur_r_d = nxt_r;
          cur_l_d = nxt_l;
          if (at_tgt) begin
            if (hold_q == '0) begin
              state_d    = IDLE;
              seg_done_d = 1'b1;
            end else begin
              state_d    = HOLD;
              hold_cnt_d = '0;
            end
          end
        end
        HOLD: if (tick) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if ((hold_cnt_q + 1'b1) == hold_q) begin
            state_d = RAMP;
            tgt_r_d = '0;
            tgt_l_d = '0;
            hold_d  = '0;
          end
        end
        STOP: begin
          if (tick) begin
            cur_r_d = nxt_r;
            cur_l_d = nxt_l;
          end
          if ((cur_r_q == '0) && (cur_l_q == '0)) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      cur_r_q    <= '0;
      cur_l_q    <= '0;
      tgt_r_q    <= '0;
      tgt_l_q    <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      seg_done_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      state_q    <= state_d;
      cur_r_q    <= cur_r_d;
      cur_l_q    <= cur_l_d;
      tgt_r_q    <= tgt_r_d;
      tgt_l_q    <= tgt_l_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      seg_done_q <= seg_done_d;
    end
  end

`ifdef MOTOR_RAMP_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_TICKS + 1);

  logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           wdog_arm;
  logic           wdog_trip_q;

  // Counts idle ticks spent at a nonzero speed; any accepted command restarts it.
  assign wdog_arm  = ((state_q == IDLE) || (state_q == HOLD)) &&
                     ((cur_r_q != '0) || (cur_l_q != '0));
  assign wdog_fire = wdog_arm && tick && (wdog_cnt_q == WDW'(WDOG_TICKS - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (estop || accept || !wdog_arm || wdog_fire) wdog_cnt_d = '0;
    else if (tick)                                  wdog_cnt_d = wdog_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_fire && !estop && !accept;
    end
  end

  assign wdog_trip = wdog_trip_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_TICKS;
  assign wdog_fire   = 1'b0;
  assign wdog_trip   = 1'b0;
`endif

  assign r_target_rot_v = cur_r_q;
  assign l_target_rot_v = cur_l_q;
  assign seg_done       = seg_done_q;
  assign state          = state_q;

endmodule
